// File: rtl/miner_work_scheduler.sv
// ---------------------------------------------------------------------------
// miner_work_scheduler
//
// Hands one block-header job at a time to an array of NUM_CORES sha256 miner
// cores. The 32-bit nonce space is split evenly: core i starts scanning at
// i << (32 - log2(NUM_CORES)). Golden nonces from the cores land in a
// per-core one-entry pending register. A round-robin arbiter moves one
// pending entry per cycle into a show-ahead result FIFO, tagged with the
// job's work_id.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high. The producer holds valid and its payload
// steady until that edge. Ready never depends combinationally on valid.
//   work_valid/work_ready : host -> scheduler job; ready only in IDLE
//   res_valid/res_ready   : scheduler -> host result; res_* show the FIFO head
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   work_valid/ready/midstate/data/id   host job interface
//   abort                       pulse: cancel the running job
//   core_midstate, core_data    registered job payload, shared by all cores
//   core_start, core_abort      one-cycle pulses to the cores
//   core_base                   constant base nonce per core, [32i+:32]
//   core_found, core_nonce      golden-nonce pulse and value per core
//   core_done                   level: core has exhausted its range
//   res_valid/ready/nonce/id    result FIFO head and pop
//   busy                        job in progress (state != IDLE)
//   overflow                    sticky: a found nonce was dropped
//   state_dbg                   current FSM state (IDLE=0 LOAD=1 RUN=2 DRAIN=3)
// ---------------------------------------------------------------------------
module miner_work_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int RES_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [255:0]              work_midstate,
    input  logic [95:0]               work_data,
    input  logic [7:0]                work_id,
    input  logic                      abort,
    output logic [255:0]              core_midstate,
    output logic [95:0]               core_data,
    output logic                      core_start,
    output logic                      core_abort,
    output logic [32*NUM_CORES-1:0]   core_base,
    input  logic [NUM_CORES-1:0]      core_found,
    input  logic [32*NUM_CORES-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_nonce,
    output logic [7:0]                res_id,
    output logic                      busy,
    output logic                      overflow,
    output logic [1:0]                state_dbg
);

    localparam int NB         = $clog2(NUM_CORES);
    localparam int CW         = (NB == 0) ? 1 : NB;
    localparam int BASE_SHIFT = 32 - NB;
    localparam int AW         = $clog2(RES_DEPTH);
    localparam int PW         = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]           cur_id;
    logic                 run_seen;     // high from the 2nd RUN cycle on
    logic                 capture_en;
    logic                 abort_take;   // abort that actually cancels a job
    logic [NUM_CORES-1:0] found_cap;

    logic [NUM_CORES-1:0] pend_valid;
    logic [31:0]          pend_nonce [NUM_CORES];

    logic [CW-1:0]        rr_ptr;       // last granted core
    logic [CW-1:0]        gnt_idx;
    logic [CW-1:0]        cand;
    logic                 gnt_any;
    logic [NUM_CORES-1:0] grant;
    logic                 can_push;

    logic [39:0]          fifo_mem [RES_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 fifo_full, fifo_empty, fifo_pop;

    // ---------------- nonce split ----------------
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
        assign core_base[32*g +: 32] = 32'(g) << BASE_SHIFT;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (work_valid) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                        state_nxt = S_IDLE;
                else if (run_seen && &core_done)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // A capture arriving in the same cycle keeps us here so the
                // entry is not stranded after the job is closed.
                if (abort)                                         state_nxt = S_IDLE;
                else if (pend_valid == '0 && found_cap == '0)      state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        work_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
        core_start = (state == S_LOAD);
        state_dbg  = state;
    end

    assign capture_en = (state == S_RUN) || (state == S_DRAIN);
    assign abort_take = abort && capture_en;
    assign found_cap  = core_found & {NUM_CORES{capture_en}};

    // ---------------- job latch, run tracking, core_abort ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_midstate <= '0;
            core_data     <= '0;
            cur_id        <= '0;
            run_seen      <= 1'b0;
            core_abort    <= 1'b0;
        end else begin
            if (state == S_IDLE && work_valid) begin
                core_midstate <= work_midstate;
                core_data     <= work_data;
                cur_id        <= work_id;
            end
            run_seen   <= (state == S_RUN);
            core_abort <= (state == S_RUN) && abort;
        end
    end

    // ---------------- round-robin arbiter ----------------
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign can_push = !fifo_full || res_ready;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        cand    = '0;
        grant   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            // NUM_CORES is a power of two, so truncation to CW bits is the wrap.
            cand = (NUM_CORES == 1) ? '0 : CW'(int'(rr_ptr) + k);
            if (!gnt_any && can_push && pend_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    // ---------------- pending registers, overflow, rr pointer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= '0;
            overflow   <= 1'b0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
        end else begin
            if (gnt_any) rr_ptr <= gnt_idx;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (abort_take) begin
                    pend_valid[i] <= 1'b0;
                end else if (found_cap[i]) begin
                    // Slot is free, or is being emptied by this cycle's grant.
                    if (!pend_valid[i] || grant[i]) begin
                        pend_valid[i] <= 1'b1;
                        pend_nonce[i] <= core_nonce[32*i +: 32];
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (grant[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- result FIFO (show-ahead) ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop   = res_ready && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < RES_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (gnt_any) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {pend_nonce[gnt_idx], cur_id};
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign res_valid = !fifo_empty;
    assign res_nonce = fifo_mem[rd_ptr[AW-1:0]][39:8];
    assign res_id    = fifo_mem[rd_ptr[AW-1:0]][7:0];

endmodule

// File: tb/tb_miner_work_scheduler.sv
module tb_miner_work_scheduler;

    logic         clk;
    logic         rst_n;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [7:0]   work_id;
    logic         abort;
    logic [255:0] core_midstate;
    logic [95:0]  core_data;
    logic         core_start;
    logic         core_abort;
    logic [127:0] core_base;
    logic [3:0]   core_found;
    logic [127:0] core_nonce;
    logic [3:0]   core_done;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic [7:0]   res_id;
    logic         busy;
    logic         overflow;
    logic [1:0]   state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // expected results in FIFO order: {nonce, id}
    logic [39:0] exp_q[$];
    logic [39:0] exp_e;

    miner_work_scheduler #(.NUM_CORES(4), .RES_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_data(work_data), .work_id(work_id),
        .abort(abort),
        .core_midstate(core_midstate), .core_data(core_data),
        .core_start(core_start), .core_abort(core_abort), .core_base(core_base),
        .core_found(core_found), .core_nonce(core_nonce), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_nonce(res_nonce), .res_id(res_id),
        .busy(busy), .overflow(overflow), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one active edge, then settle so outputs are sampled away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        work_valid = 1'b0; abort = 1'b0; core_found = '0; core_done = '0;
        res_ready = 1'b0; core_nonce = '0;
    endtask

    task automatic start_job(input logic [7:0] id, input logic [255:0] ms, input logic [95:0] dt);
        work_valid = 1'b1; work_id = id; work_midstate = ms; work_data = dt;
        step();                 // IDLE -> LOAD
        work_valid = 1'b0;
        step();                 // LOAD -> RUN
    endtask

    task automatic found_one(input int core, input logic [31:0] nonce);
        core_found = '0;
        core_found[core] = 1'b1;
        core_nonce[32*core +: 32] = nonce;
    endtask

    // pop one result and compare the head against the scoreboard
    task automatic pop_check(input string name);
        exp_e = exp_q.pop_front();
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL %s valid: got %b expected 1", name, res_valid); end
        n_vec++; if (res_nonce !== exp_e[39:8]) begin n_err++; $display("FAIL %s nonce: got %h expected %h", name, res_nonce, exp_e[39:8]); end
        n_vec++; if (res_id !== exp_e[7:0]) begin n_err++; $display("FAIL %s id: got %h expected %h", name, res_id, exp_e[7:0]); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        work_id = '0; work_midstate = '0; work_data = '0;
        step(); step();
        n_vec++; if (work_ready !== 1'b1) begin n_err++; $display("FAIL reset work_ready: got %b expected 1", work_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset res_valid: got %b expected 0", res_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b expected 0", overflow); end
        n_vec++; if ({core_start, core_abort} !== 2'b00) begin n_err++; $display("FAIL reset pulses: got %b expected 00", {core_start, core_abort}); end
        n_vec++; if (core_midstate !== 256'd0 || core_data !== 96'd0) begin n_err++; $display("FAIL reset payload: got %h/%h expected 0", core_midstate, core_data); end
        n_vec++; if (res_nonce !== 32'd0 || res_id !== 8'd0) begin n_err++; $display("FAIL reset res: got %h/%h expected 0", res_nonce, res_id); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        // core bases for 4 cores: i << 30
        n_vec++; if (core_base !== {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}) begin n_err++; $display("FAIL core_base: got %h expected c0000000800000004000000000000000", core_base); end
        work_valid = 1'b1; work_id = 8'h5A;
        work_midstate = {8{32'hDEAD_BEEF}}; work_data = {3{32'h1234_5678}};
        step();
        work_valid = 1'b0;
        n_vec++; if (core_start !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL load start/busy: got %b%b expected 11", core_start, busy); end
        n_vec++; if (core_midstate !== {8{32'hDEAD_BEEF}} || core_data !== {3{32'h1234_5678}}) begin n_err++; $display("FAIL load payload: got %h/%h expected deadbeef../12345678..", core_midstate, core_data); end
        n_vec++; if (work_ready !== 1'b0) begin n_err++; $display("FAIL load work_ready: got %b expected 0", work_ready); end
        step();
        n_vec++; if (core_start !== 1'b0 || state_dbg !== 2'd2) begin n_err++; $display("FAIL run entry: got start=%b state=%0d expected 0/2", core_start, state_dbg); end
        found_one(2, 32'h8000_1234);
        step();                 // captured into pending[2]
        core_found = '0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single early: got res_valid %b expected 0", res_valid); end
        step();                 // granted and pushed
        exp_q.push_back({32'h8000_1234, 8'h5A});
        pop_check("single");
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single empty: got %b expected 0", res_valid); end
    endtask

    task automatic test_all_cores();
        // last grant was core 2, so the order is 3, 0, 1, 2
        core_found = 4'b1111;
        core_nonce = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0010};
        res_ready = 1'b1;
        step();                 // all four captured
        core_found = '0;
        exp_q.push_back({32'h3333_0003, 8'h5A});
        exp_q.push_back({32'h0000_0010, 8'h5A});
        exp_q.push_back({32'h1111_0001, 8'h5A});
        exp_q.push_back({32'h2222_0002, 8'h5A});
        for (int k = 0; k < 4; k++) begin
            step();             // pushes the next grant, pops the previous head
            exp_e = exp_q.pop_front();
            n_vec++; if (res_valid !== 1'b1 || res_nonce !== exp_e[39:8] || res_id !== exp_e[7:0]) begin
                n_err++; $display("FAIL rr order %0d: got v=%b %h/%h expected %h/%h", k, res_valid, res_nonce, res_id, exp_e[39:8], exp_e[7:0]);
            end
        end
        step();
        res_ready = 1'b0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rr drained: got %b expected 0", res_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rr overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_fifo_full_and_drain();
        // nine pulses, one per cycle, cores 0,1,2,3,0,...; the ninth stays pending on core 0
        for (int k = 0; k < 9; k++) begin
            found_one(k % 4, 32'hA000_0000 + 32'(k));
            exp_q.push_back({32'hA000_0000 + 32'(k), 8'h5A});
            step();
        end
        core_found = '0;
        step();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full no-ovf: got %b expected 0", overflow); end
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL full res_valid: got %b expected 1", res_valid); end
        found_one(0, 32'hBAD0_BAD0);   // core 0 still pending, FIFO full: dropped
        step();
        core_found = '0;
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow set: got %b expected 1", overflow); end
        // all cores done while core 0 is held pending
        core_done = 4'b1111;
        step();
        n_vec++; if (state_dbg !== 2'd3 || busy !== 1'b1) begin n_err++; $display("FAIL drain entry: got state=%0d busy=%b expected 3/1", state_dbg, busy); end
        step();
        n_vec++; if (state_dbg !== 2'd3 || work_ready !== 1'b0) begin n_err++; $display("FAIL drain hold: got state=%0d ready=%b expected 3/0", state_dbg, work_ready); end
        pop_check("full pop0");        // frees a slot: pending core 0 granted this edge
        n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL drain after grant: got state=%0d expected 3", state_dbg); end
        step();
        core_done = '0;
        n_vec++; if (work_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL drain exit: got ready=%b busy=%b expected 1/0", work_ready, busy); end
        for (int k = 1; k < 9; k++) pop_check("full drain");
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL full empty: got %b expected 0", res_valid); end
    endtask

    task automatic test_reset_mid_run();
        start_job(8'h11, {8{32'h0101_0101}}, {3{32'h0202_0202}});
        found_one(2, 32'h7777_0000);
        step();
        core_found = '0;
        step();
        n_vec++; if (busy !== 1'b1 || res_valid !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL pre-reset: got busy=%b v=%b ovf=%b expected 111", busy, res_valid, overflow); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || work_ready !== 1'b1) begin n_err++; $display("FAIL async reset: got busy=%b ready=%b expected 0/1", busy, work_ready); end
        step();
        n_vec++; if (res_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL mid reset: got v=%b ovf=%b expected 0/0", res_valid, overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_abort();
        abort = 1'b1;           // ignored in IDLE
        step();
        abort = 1'b0;
        n_vec++; if (core_abort !== 1'b0 || work_ready !== 1'b1) begin n_err++; $display("FAIL idle abort: got cab=%b ready=%b expected 0/1", core_abort, work_ready); end
        found_one(1, 32'h5555_5555);   // ignored outside RUN/DRAIN
        step();
        core_found = '0;
        step(); step();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL idle found: got %b expected 0", res_valid); end
        work_valid = 1'b1; work_id = 8'hC3;
        step();                 // LOAD
        work_valid = 1'b0;
        abort = 1'b1;           // ignored in LOAD
        step();
        abort = 1'b0;
        n_vec++; if (state_dbg !== 2'd2 || core_abort !== 1'b0) begin n_err++; $display("FAIL load abort: got state=%0d cab=%b expected 2/0", state_dbg, core_abort); end
        core_found = 4'b1010;
        core_nonce[63:32]  = 32'h1111_AAAA;
        core_nonce[127:96] = 32'h3333_BBBB;
        step();
        core_found = '0;
        step(); step();         // rr reset to 0: core 1 then core 3
        exp_q.push_back({32'h1111_AAAA, 8'hC3});
        exp_q.push_back({32'h3333_BBBB, 8'hC3});
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_vec++; if (core_abort !== 1'b1 || busy !== 1'b0 || work_ready !== 1'b1) begin n_err++; $display("FAIL run abort: got cab=%b busy=%b ready=%b expected 1/0/1", core_abort, busy, work_ready); end
        step();
        n_vec++; if (core_abort !== 1'b0) begin n_err++; $display("FAIL abort pulse width: got %b expected 0", core_abort); end
        pop_check("abort q0");
        pop_check("abort q1");
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL abort empty: got %b expected 0", res_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_all_cores();
        test_fifo_full_and_drain();
        test_reset_mid_run();
        test_abort();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
